// File: rtl/mod_reduce_if.sv
// Operand/result bundle for the modular reducer. The requester drives the
// start strobe and operands; the reducer returns the result, its status and
// the busy flag.
interface mod_reduce_if #(
  parameter int N = 256
);
  logic             en;
  logic [2*N-1:0]   prod;
  logic [N-1:0]     mod_p;
  logic [N-1:0]     rem;
  logic             data_rdy;
  logic             busy;
  logic             err;

  modport master (
    output en, prod, mod_p,
    input  rem, data_rdy, busy, err
  );

  modport slave (
    input  en, prod, mod_p,
    output rem, data_rdy, busy, err
  );
endinterface

// File: rtl/mod_reduce.sv
// Bit-serial modular reduction: rem = prod mod mod_p, with a 2N-bit dividend
// and an N-bit modulus. One restoring shift-subtract step is taken per clock,
// MSB of the dividend first, so a reduction takes 2N cycles. A zero modulus
// is flagged in a single cycle without entering the reduction loop.
module mod_reduce #(
  parameter int N = 256
) (
  input  logic      clk,
  input  logic      rst,
  mod_reduce_if.slave bus
);
  localparam int CW = $clog2(2 * N);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic [N-1:0]     p_q, p_d;
  logic [N:0]       r_q, r_d;     // one spare bit so the shift never overflows
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     rem_q, rem_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;

  logic [N:0]       t;
  logic [N:0]       t_sub;
  logic             ge;

  // Datapath for one restoring step: bring in the next dividend bit and trial-subtract.
  always_comb begin
    t     = (r_q << 1) | {{N{1'b0}}, prod_q[cnt_q]};
    ge    = (t >= {1'b0, p_q});
    t_sub = t - {1'b0, p_q};
  end

  // Next-state and output logic; data_rdy is a single-cycle pulse by default-low.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    p_d     = p_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    err_d   = err_q;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          if (bus.mod_p == '0) begin
            // Division by zero: report immediately, no reduction loop.
            rem_d = '0;
            err_d = 1'b1;
            rdy_d = 1'b1;
          end else begin
            prod_d  = bus.prod;
            p_d     = bus.mod_p;
            r_d     = '0;
            cnt_d   = CW'(2 * N - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Starts arriving here are ignored; operands are already latched.
        r_d   = ge ? t_sub : t;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          rem_d   = r_d[N-1:0];
          err_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset clearing everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      p_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      p_q     <= p_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.rem      = rem_q;
  assign bus.err      = err_q;
  assign bus.data_rdy = rdy_q;
  assign bus.busy     = (state_q == RUN);
endmodule

// File: tb/tb_mod_reduce.sv
// Self-checking bench for mod_reduce: expected results are computed with
// wide arithmetic when a start is driven, queued with their due cycle, and
// compared when data_rdy is seen.
module tb_mod_reduce;
  localparam int N = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_reduce_if #(.N(N)) bus ();

  mod_reduce #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] rem;
    logic         err;
    int           t;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every data_rdy must match the oldest outstanding start.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.data_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_rdy", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn @%0d rem=%0h err=%0b", cyc, bus.rem, bus.err);
        chk("rem", bus.rem, e.rem);
        chk("err", bus.err, e.err);
        chk("rdy_time", cyc, e.t);
      end
    end
  end

  function automatic logic [2*N-1:0] rand_wide();
    logic [2*N-1:0] v;
    for (int i = 0; i < 2 * N / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Called at a negedge; the following posedge samples the start.
  task automatic start(input logic [2*N-1:0] pr, input logic [N-1:0] p, input bit accept);
    exp_t e;
    logic [2*N-1:0] m;
    bus.prod  = pr;
    bus.mod_p = p;
    bus.en    = 1'b1;
    if (accept) begin
      if (p == '0) begin
        e.rem = '0;
        e.err = 1'b1;
        e.t   = cyc + 1;
      end else begin
        m     = pr % {{N{1'b0}}, p};
        e.rem = m[N-1:0];
        e.err = 1'b0;
        e.t   = cyc + 1 + 2 * N;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    bus.en    = 1'b0;
    // Scramble the operand inputs: the captured copy must be used.
    bus.prod  = rand_wide();
    bus.mod_p = $urandom();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic busy_len();
    int n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 2 * N);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*N-1:0] a;
    logic [2*N-1:0] pr;
    logic [N-1:0]   p;
    int n;

    rst = 1'b1;
    bus.en = 1'b0;
    bus.prod = '0;
    bus.mod_p = '0;
    repeat (3) @(negedge clk);
    // Start requested while in reset must be dropped.
    bus.en = 1'b1;
    bus.prod = 512'h3c;
    bus.mod_p = 256'd7;
    @(negedge clk);
    chk("rst_rem", bus.rem, 0);
    chk("rst_rdy", bus.data_rdy, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    bus.en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);

    // Basic reduction with latency and busy width.
    start(512'h3c, 256'd7, 1);
    busy_len();
    wait_idle();
    chk("q31_rem", bus.rem, 4);
    @(negedge clk);
    chk("rdy_pulse", bus.data_rdy, 0);

    // All-ones dividend over all-ones modulus.
    start({(2*N){1'b1}}, {N{1'b1}}, 1);
    wait_idle();
    chk("q32_rem", bus.rem, 0);

    // (2^N-1)^2 mod (2^N-2) = 1.
    a = {{N{1'b0}}, {N{1'b1}}};
    pr = a * a;
    start(pr, {{(N-1){1'b1}}, 1'b0}, 1);
    wait_idle();
    chk("q33_rem", bus.rem, 1);

    // Dividend below modulus, then a zero modulus.
    start(512'd5, 256'd12, 1);
    wait_idle();
    chk("q34_rem", bus.rem, 5);
    start(512'h3c, 256'd0, 1);
    wait_idle();
    chk("zero_err", bus.err, 1);
    chk("zero_rem", bus.rem, 0);
    chk("zero_busy", bus.busy, 0);

    // Modulus of one.
    start(rand_wide(), 256'd1, 1);
    wait_idle();

    // Random operands, including a dividend smaller than the modulus.
    for (int i = 0; i < 3; i++) begin
      pr = rand_wide();
      p = pr[N-1:0] ^ rand_wide();
      if (p == '0) p = 256'd3;
      start(pr, p, 1);
      wait_idle();
    end
    pr = {{N{1'b0}}, rand_wide() >> (N + 1)};
    start(pr, {1'b1, {(N-1){1'b0}}}, 1);
    wait_idle();

    // Back-to-back: new start in the cycle data_rdy is high.
    start(rand_wide(), 256'd1000003, 1);
    n = 0;
    while (bus.data_rdy !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_timeout", n < 3000, 1);
    start(rand_wide(), 256'd65537, 1);
    wait_idle();

    // Re-pulsed start during RUN is ignored.
    start(512'h3c, 256'd7, 1);
    repeat (99) @(negedge clk);
    start(rand_wide(), 256'd11, 0);
    chk("repulse_busy", bus.busy, 1);
    wait_idle();
    chk("repulse_rem", bus.rem, 4);

    // Reset mid-run aborts with no result.
    start(rand_wide(), 256'd999, 1);
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_rem", bus.rem, 0);
    chk("abort_rdy", bus.data_rdy, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_err", bus.err, 0);
    repeat (2 * N + 20) @(negedge clk);
    start(512'h3c, 256'd7, 1);
    wait_idle();
    chk("after_abort_rem", bus.rem, 4);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mod_reduce.md
MOD_REDUCE -- requirements
Module: mod_reduce

Interface
REQ-001 SHALL have parameter N, default 256, operand width of the modulus and the result; the input product is 2N bits.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port en, input, 1 bit: start strobe, sampled on the rising edge of clk.
REQ-005 SHALL have port prod, input, 2N bits: dividend, the product from the sequential multiplier, captured when a start is accepted.
REQ-006 SHALL have port mod_p, input, N bits: modulus, captured when a start is accepted.
REQ-007 SHALL have port rem, output, N bits: registered result, prod mod mod_p.
REQ-008 SHALL have port data_rdy, output, 1 bit: one-cycle pulse indicating that rem and err are valid.
REQ-009 SHALL have port busy, output, 1 bit: high while a reduction is in progress.
REQ-010 SHALL have port err, output, 1 bit: high when the captured modulus was zero; registered with rem.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and RUN.
REQ-012 In IDLE, en=1 SHALL capture prod and mod_p into internal registers, clear the partial remainder r to 0, load the bit counter with 2N-1, and enter RUN.
REQ-013 The partial remainder r SHALL be N+1 bits wide so that the shifted value never overflows before the compare.
REQ-014 Each RUN cycle SHALL compute t = (r << 1) | prod_q[cnt], then set r = t - p_q when t >= p_q, else r = t (restoring shift-subtract).
REQ-015 RUN SHALL last exactly 2N cycles, with the counter decrementing from 2N-1 to 0.
REQ-016 On the RUN cycle where cnt = 0, the block SHALL load rem with the final r[N-1:0], set data_rdy=1 and err=0, and return to IDLE.
REQ-017 Latency SHALL be 2N clock edges: for N=256, data_rdy is high in the cycle following the 512th edge after the edge that sampled en.
REQ-018 data_rdy SHALL be high for exactly one cycle per accepted start and low at all other times.
REQ-019 rem and err SHALL hold their last values until the next completion or reset.
REQ-020 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-021 en=1 while busy=1 SHALL be ignored; the captured operands and the in-progress result are unaffected.
REQ-022 Changes on prod and mod_p after capture SHALL NOT affect the result.
REQ-023 If mod_p = 0 when en is accepted, the block SHALL stay in IDLE, set rem=0 and err=1, and pulse data_rdy in the next cycle, giving 1-cycle latency.
REQ-024 mod_p = 1 SHALL yield rem=0 with err=0.
REQ-025 prod < mod_p SHALL yield rem = prod[N-1:0].
REQ-026 Back-to-back operation SHALL be supported: en asserted in the cycle data_rdy is high SHALL be accepted.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL force the FSM to IDLE and set rem=0, data_rdy=0, busy=0 and err=0, and clear all internal registers.
REQ-028 rst SHALL take priority over en in the same cycle.
REQ-029 rst asserted during RUN SHALL abort the reduction with no data_rdy pulse.
REQ-030 The first en after rst deasserts SHALL be accepted normally.

Verification
REQ-031 Bench SHALL cover: prod=0x3c, mod_p=7 -> rem=0x4, err=0, data_rdy 512 edges after the en edge, busy high for 512 cycles.
REQ-032 Bench SHALL cover: prod=2^512-1, mod_p=2^256-1 -> rem=0.
REQ-033 Bench SHALL cover: prod=0xff..fe00..01 (that is, (2^256-1)^2), mod_p=2^256-2 -> rem=1.
REQ-034 Bench SHALL cover: prod=5, mod_p=12 -> rem=5; then prod=0x3c, mod_p=0 -> err=1, rem=0, data_rdy one cycle after en.
REQ-035 Bench SHALL cover: en re-pulsed with new operands 100 cycles into RUN -> the original result is still produced at the original time.
REQ-036 Bench SHALL cover: rst pulsed 200 cycles into RUN -> all outputs 0 and no data_rdy; a subsequent prod=0x3c, mod_p=7 -> rem=4.
